// File: rtl/addsub_serial_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Ceiling log2; returns 0 for n <= 1, callers clamp to a 1-bit minimum.
    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// Latency: n/a (wiring only).
// Backpressure: IN_VALID/IN_READY on the operand side, OUT_VALID/OUT_READY on the result side.
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MODE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OV;
    logic             Z;

    // Producer of operands and consumer of results.
    modport master (
        output IN_VALID, A, B, MODE, OUT_READY,
        input  IN_READY, OUT_VALID, S, CO, OV, Z
    );

    // The arithmetic block itself.
    modport slave (
        input  IN_VALID, A, B, MODE, OUT_READY,
        output IN_READY, OUT_VALID, S, CO, OV, Z
    );
endinterface

// File: rtl/addsub_serial_digit.sv
// One DIGIT-wide add/sub slice, reused every cycle by the serial engine.
// Latency: combinational.
// Backpressure: none.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             mode,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT-1:0] b_eff;

    // Subtraction inverts B here; the +1 arrives through ci on the first digit.
    assign b_eff = b ^ {DIGIT{mode}};
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, ci};

    // Carry into the slice MSB, recovered from the MSB sum bit; needed for signed overflow.
    assign c_msb = s[DIGIT-1] ^ a[DIGIT-1] ^ b_eff[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement A+B / A-B with carry, overflow and zero flags.
// Latency: OUT_VALID rises WIDTH/DIGIT edges after the accept edge.
// Backpressure: one operation in flight; IN_READY low until the result is taken with OUT_READY.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    addsub_serial_if.slave    bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              mode_q, mode_d;
    logic              carry_q, carry_d;
    logic              co_q, co_d;
    logic              ov_q, ov_d;
    logic              z_q, z_d;

    logic [DIGIT-1:0]  dig_a, dig_b, dig_s;
    logic              dig_co, dig_cmsb;
    logic              last_dig;

    assign dig_a    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign dig_b    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .mode  (mode_q),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // Next-state: accept in IDLE, one digit per RUN cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    mode_d  = bus.MODE;
                    carry_d = (bus.MODE == MODE_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_s;
                carry_d = dig_co;
                if (last_dig) begin
                    // The last slice's MSB is the word MSB, so its carries give the flags.
                    co_d    = dig_co;
                    ov_d    = dig_cmsb ^ dig_co;
                    z_d     = ~|s_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and drops any pending result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
        end
    end

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.CO        = co_q;
    assign bus.OV        = ov_q;
    assign bus.Z         = z_q;
endmodule
